// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM port arbiter.
// State encodings, client ids and read latency.
package ram_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int CLIENT0    = 0;
  localparam int CLIENT1    = 1;
  localparam int RD_LATENCY = 1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Client-side bus of the RAM port arbiter.
// Two write clients and two dedicated read ports.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);

  logic                  iWrReq0;
  logic                  iWrReq1;
  logic [ADDR_WIDTH-1:0] iWrAddr0;
  logic [ADDR_WIDTH-1:0] iWrAddr1;
  logic [DATA_WIDTH-1:0] iWrData0;
  logic [DATA_WIDTH-1:0] iWrData1;
  logic                  oWrGnt0;
  logic                  oWrGnt1;
  logic                  iRdReq0;
  logic                  iRdReq1;
  logic [ADDR_WIDTH-1:0] iRdAddr0;
  logic [ADDR_WIDTH-1:0] iRdAddr1;
  logic                  oRdValid0;
  logic                  oRdValid1;
  logic [DATA_WIDTH-1:0] oRdData0;
  logic [DATA_WIDTH-1:0] oRdData1;

  modport slave (
    input  iWrReq0, iWrReq1,
    input  iWrAddr0, iWrAddr1,
    input  iWrData0, iWrData1,
    output oWrGnt0, oWrGnt1,
    input  iRdReq0, iRdReq1,
    input  iRdAddr0, iRdAddr1,
    output oRdValid0, oRdValid1,
    output oRdData0, oRdData1
  );

  modport master (
    output iWrReq0, iWrReq1,
    output iWrAddr0, iWrAddr1,
    output iWrData0, iWrData1,
    input  oWrGnt0, oWrGnt1,
    output iRdReq0, iRdReq1,
    output iRdAddr0, iRdAddr1,
    input  oRdValid0, oRdValid1,
    input  oRdData0, oRdData1
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Pointer flips to the other client after any grant.
module rr_arbiter2 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic r_ptr;

  // grant the lone requester, or the favoured one on contention
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      req[0] && (!req[1] || !r_ptr): gnt = 2'b01;
      req[1] && (!req[0] ||  r_ptr): gnt = 2'b10;
      default:                       gnt = 2'b00;
    endcase
  end

  // pointer favours the client that was not just served
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_ptr <= 1'b0;
    end else if (gnt[0]) begin
      r_ptr <= 1'b1;
    end else if (gnt[1]) begin
      r_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Write-port arbitration, read bypass and zero-fill sweep
// in front of a dual-read-port RAM.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iClear,
  output logic                  oBusy,
  ram_port_arbiter_if.slave     bus,
  output logic                  oAddrErr,
  output logic                  oRamWriteEnable,
  output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
  output logic [DATA_WIDTH-1:0] oRamDataIn,
  output logic [ADDR_WIDTH-1:0] oRamReadAddress0,
  output logic [ADDR_WIDTH-1:0] oRamReadAddress1,
  input  logic [DATA_WIDTH-1:0] iRamDataOut0,
  input  logic [DATA_WIDTH-1:0] iRamDataOut1
);

  localparam logic [ADDR_WIDTH-1:0] MAX_A =
    ADDR_WIDTH'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] MAX_C =
    (ADDR_WIDTH+1)'(MEM_SIZE);

  state_t                r_state;
  state_t                w_state_nx;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH:0]   w_cnt_nx;
  logic                  w_run;
  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_wr_oob;
  logic                  r_err;

  logic [1:0]            w_acc;
  logic [1:0]            w_rd_oob;
  logic [ADDR_WIDTH-1:0] w_rd_addr [2];
  logic [DATA_WIDTH-1:0] w_ram_do  [2];
  logic [DATA_WIDTH-1:0] w_rd_data [2];
  logic [DATA_WIDTH-1:0] w_rd_out  [2];
  logic [1:0]            r_vld;
  logic [1:0]            r_byp;
  logic [1:0]            r_oob;
  logic [DATA_WIDTH-1:0] r_bdata   [2];
  logic [DATA_WIDTH-1:0] r_hold    [2];

  // FSM state and sweep counter registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // next state: sweep to MEM_SIZE, iClear restarts it
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      ST_CLEAR: begin
        if (iClear) begin
          w_cnt_nx = '0;
        end else if (r_cnt == MAX_C) begin
          w_state_nx = ST_RUN;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (iClear) begin
          w_state_nx = ST_CLEAR;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        w_state_nx = ST_CLEAR;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign oBusy = (r_state == ST_CLEAR);
  assign w_run = (r_state == ST_RUN) && !iClear;
  assign w_req = {bus.iWrReq1, bus.iWrReq0} & {2{w_run}};

  rr_arbiter2 u_arb (
    .Clock (Clock),
    .Reset (Reset),
    .req   (w_req),
    .gnt   (w_gnt)
  );

  assign bus.oWrGnt0 = w_gnt[CLIENT0];
  assign bus.oWrGnt1 = w_gnt[CLIENT1];

  assign w_wr_addr = w_gnt[CLIENT1] ? bus.iWrAddr1
                                    : bus.iWrAddr0;
  assign w_wr_data = w_gnt[CLIENT1] ? bus.iWrData1
                                    : bus.iWrData0;
  assign w_wr_oob  = (|w_gnt) && (w_wr_addr > MAX_A);

  // RAM write port: sweep zeros, or the granted client
  always_comb begin
    oRamWriteEnable  = 1'b0;
    oRamWriteAddress = '0;
    oRamDataIn       = '0;
    if (r_state == ST_CLEAR) begin
      oRamWriteEnable  = Reset;
      oRamWriteAddress = r_cnt[ADDR_WIDTH-1:0];
    end else if (|w_gnt) begin
      oRamWriteEnable  = !w_wr_oob;
      oRamWriteAddress = w_wr_addr;
      oRamDataIn       = w_wr_data;
    end
  end

  assign oRamReadAddress0 = bus.iRdAddr0;
  assign oRamReadAddress1 = bus.iRdAddr1;

  assign w_rd_addr[0] = bus.iRdAddr0;
  assign w_rd_addr[1] = bus.iRdAddr1;
  assign w_ram_do[0]  = iRamDataOut0;
  assign w_ram_do[1]  = iRamDataOut1;
  assign w_acc        = {bus.iRdReq1, bus.iRdReq0}
                      & {2{w_run}};

  // per-port data select: zero, bypassed write, or RAM
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_rd_oob[k]  = w_rd_addr[k] > MAX_A;
      w_rd_data[k] = r_oob[k] ? '0
                   : r_byp[k] ? r_bdata[k]
                   : w_ram_do[k];
      w_rd_out[k]  = r_vld[k] ? w_rd_data[k]
                              : r_hold[k];
    end
  end

  // read pipeline: valid, bypass capture and output hold
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_vld <= '0;
      r_byp <= '0;
      r_oob <= '0;
      for (int k = 0; k < 2; k++) begin
        r_bdata[k] <= '0;
        r_hold[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        r_vld[k] <= w_acc[k];
        if (w_acc[k]) begin
          r_oob[k]   <= w_rd_oob[k];
          r_byp[k]   <= oRamWriteEnable &&
                        (w_rd_addr[k] == oRamWriteAddress);
          r_bdata[k] <= oRamDataIn;
        end
        if (r_vld[k]) begin
          r_hold[k] <= w_rd_data[k];
        end
      end
    end
  end

  assign bus.oRdValid0 = r_vld[0];
  assign bus.oRdValid1 = r_vld[1];
  assign bus.oRdData0  = w_rd_out[0];
  assign bus.oRdData1  = w_rd_out[1];

  // sticky out-of-range flag, dropped by iClear
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_err <= 1'b0;
    end else if (iClear) begin
      r_err <= 1'b0;
    end else if (w_wr_oob || |(w_acc & w_rd_oob)) begin
      r_err <= 1'b1;
    end
  end

  assign oAddrErr = r_err;

endmodule
